// File: rtl/dmg_fb_reader_if.sv
// dmg_fb_reader_if: PPU pixel stream, panel read port and status flags of the DMG frame buffer.
interface dmg_fb_reader_if;
  logic       pix_frame_start;
  logic       pix_valid;
  logic [1:0] pix_data;
  logic [8:0] rd_x;
  logic [7:0] rd_y;
  logic       rd_frame_start;
  logic [1:0] data_out;
  logic       frame_done;
  logic       overflow;
  logic       short_frame;
  logic       frame_dropped;
  logic       clr_status;

  modport master (
    output pix_frame_start, pix_valid, pix_data, rd_x, rd_y, rd_frame_start, clr_status,
    input  data_out, frame_done, overflow, short_frame, frame_dropped
  );

  modport slave (
    input  pix_frame_start, pix_valid, pix_data, rd_x, rd_y, rd_frame_start, clr_status,
    output data_out, frame_done, overflow, short_frame, frame_dropped
  );
endinterface

// File: rtl/dmg_fb_reader.sv
// dmg_fb_reader: captures 160x144 2-bit PPU frames and serves them by (x, y) lookup to the LCD panel.
// Define DMG_FB_DOUBLE_BUF_EN for two banks with panel-synchronised bank swap and frame_dropped.
module dmg_fb_reader #(
  parameter int         H_PIX     = 160,
  parameter int         V_PIX     = 144,
  parameter logic [1:0] BLANK_PIX = 2'b00
) (
  input logic           clk_8m,
  input logic           rst,
  dmg_fb_reader_if.slave bus
);
  localparam int NPIX = H_PIX * V_PIX;

  typedef enum logic [1:0] {IDLE = 2'd0, FILL = 2'd1, FULL = 2'd2} state_t;

  state_t      state_r;
  logic [7:0]  wr_x_r, wr_y_r;
  logic        frame_valid_r, frame_done_r, overflow_r, short_frame_r;
  logic [1:0]  data_out_r;

  logic        wr_en_s, last_s, ovf_set_s, short_set_s, valid_set_s, rd_ok_s, wr_bank_s;
  logic [14:0] wr_addr_s, rd_addr_s;
  logic [1:0]  rd_pix_s;

  // y*160 + x built from shifts so no multiplier is inferred.
  function automatic logic [14:0] lin_addr(input logic [7:0] y, input logic [8:0] x);
    lin_addr = {y, 7'd0} + {2'd0, y, 5'd0} + {6'd0, x};
  endfunction

  // Write port decode: a frame start restarts the raster, so a same-cycle pixel lands at (0,0).
  always_comb begin
    wr_en_s     = 1'b0;
    wr_addr_s   = 15'd0;
    last_s      = 1'b0;
    ovf_set_s   = 1'b0;
    short_set_s = 1'b0;
    if (bus.pix_frame_start) begin
      wr_en_s     = bus.pix_valid;
      short_set_s = (state_r == FILL) && ((wr_x_r != 8'd0) || (wr_y_r != 8'd0));
    end else if (state_r == FILL) begin
      wr_en_s   = bus.pix_valid;
      wr_addr_s = lin_addr(wr_y_r, {1'b0, wr_x_r});
      last_s    = bus.pix_valid && (wr_x_r == 8'(H_PIX - 1)) && (wr_y_r == 8'(V_PIX - 1));
    end else if (state_r == FULL) begin
      ovf_set_s = bus.pix_valid;
    end else begin
      wr_en_s = 1'b0;
    end
  end

  assign rd_addr_s = lin_addr(bus.rd_y, bus.rd_x);
  assign rd_ok_s   = frame_valid_r && (bus.rd_x < 9'(H_PIX)) && (bus.rd_y < 8'(V_PIX));

`ifdef DMG_FB_DOUBLE_BUF_EN
  logic       rb_r, wb_r, pending_r, frame_dropped_r;
  logic       swap_s, rb_next_s, wb_next_s, pend_mid_s, drop_s;
  logic [1:0] mem_r [0:1][0:NPIX-1];

  // Panel swap is resolved before the PPU picks its new write bank, so wb never equals the shown bank.
  always_comb begin
    swap_s     = bus.rd_frame_start && pending_r;
    rb_next_s  = swap_s ? wb_r : rb_r;
    pend_mid_s = pending_r && !swap_s;
    drop_s     = bus.pix_frame_start && pend_mid_s;
    wb_next_s  = bus.pix_frame_start ? ~rb_next_s : wb_r;
  end

  // Bank pointers, pending frame and the dropped-frame flag.
  always_ff @(posedge clk_8m) begin
    if (rst) begin
      rb_r            <= 1'b0;
      wb_r            <= 1'b1;
      pending_r       <= 1'b0;
      frame_dropped_r <= 1'b0;
    end else begin
      rb_r            <= rb_next_s;
      wb_r            <= wb_next_s;
      pending_r       <= last_s ? 1'b1 : (drop_s ? 1'b0 : pend_mid_s);
      frame_dropped_r <= drop_s ? 1'b1 : (bus.clr_status ? 1'b0 : frame_dropped_r);
    end
  end

  // The panel only sees real data once it has adopted a completed bank.
  assign valid_set_s       = swap_s;
  assign wr_bank_s         = wb_next_s;
  assign rd_pix_s          = mem_r[rb_r][rd_addr_s];
  assign bus.frame_dropped = frame_dropped_r;

  // Pixel store; no reset so the array maps onto block RAM.
  always_ff @(posedge clk_8m) begin
    if (wr_en_s && !rst) begin
      mem_r[wr_bank_s][wr_addr_s] <= bus.pix_data;
    end
  end
`else
  logic [1:0] mem_r [0:NPIX-1];
  logic       unused_rd_frame_start_s;

  assign valid_set_s             = last_s;
  assign wr_bank_s               = 1'b0;
  assign rd_pix_s                = mem_r[rd_addr_s];
  assign bus.frame_dropped       = 1'b0;
  assign unused_rd_frame_start_s = bus.rd_frame_start ^ wr_bank_s;

  // Pixel store; no reset so the array maps onto block RAM.
  always_ff @(posedge clk_8m) begin
    if (wr_en_s && !rst) begin
      mem_r[wr_addr_s] <= bus.pix_data;
    end
  end
`endif

  // Write FSM: raster counters, completion pulse and sticky status flags.
  always_ff @(posedge clk_8m) begin
    if (rst) begin
      state_r       <= IDLE;
      wr_x_r        <= 8'd0;
      wr_y_r        <= 8'd0;
      frame_valid_r <= 1'b0;
      frame_done_r  <= 1'b0;
      overflow_r    <= 1'b0;
      short_frame_r <= 1'b0;
    end else begin
      frame_done_r  <= last_s;
      frame_valid_r <= frame_valid_r | valid_set_s;
      overflow_r    <= ovf_set_s   ? 1'b1 : (bus.clr_status ? 1'b0 : overflow_r);
      short_frame_r <= short_set_s ? 1'b1 : (bus.clr_status ? 1'b0 : short_frame_r);
      if (bus.pix_frame_start) begin
        state_r <= FILL;
        wr_x_r  <= bus.pix_valid ? 8'd1 : 8'd0;
        wr_y_r  <= 8'd0;
      end else begin
        case (state_r)
          IDLE: state_r <= IDLE;
          FILL: begin
            if (last_s) begin
              state_r <= FULL;
              wr_x_r  <= 8'd0;
              wr_y_r  <= 8'd0;
            end else if (bus.pix_valid && (wr_x_r == 8'(H_PIX - 1))) begin
              wr_x_r <= 8'd0;
              wr_y_r <= wr_y_r + 8'd1;
            end else if (bus.pix_valid) begin
              wr_x_r <= wr_x_r + 8'd1;
            end
          end
          FULL:    state_r <= FULL;
          default: state_r <= IDLE;
        endcase
      end
    end
  end

  // Registered read port, one cycle after the address is presented.
  always_ff @(posedge clk_8m) begin
    if (rst) begin
      data_out_r <= BLANK_PIX;
    end else if (rd_ok_s) begin
      data_out_r <= rd_pix_s;
    end else begin
      data_out_r <= BLANK_PIX;
    end
  end

  assign bus.data_out    = data_out_r;
  assign bus.frame_done  = frame_done_r;
  assign bus.overflow    = overflow_r;
  assign bus.short_frame = short_frame_r;
endmodule

// File: tb/tb_dmg_fb_reader.sv
// tb_dmg_fb_reader: randomized stimulus checked every cycle against a pixel-count based frame buffer model.
module tb_dmg_fb_reader;
`ifdef DMG_FB_DOUBLE_BUF_EN
  localparam bit DB = 1'b1;
`else
  localparam bit DB = 1'b0;
`endif
  localparam int NPIX = 160 * 144;

  logic clk_8m = 1'b0;
  logic rst    = 1'b1;
  always #62 clk_8m = ~clk_8m;

  dmg_fb_reader_if bus ();
  dmg_fb_reader dut (.clk_8m(clk_8m), .rst(rst), .bus(bus));

  int total = 0;
  int bad = 0;
  int done_seen = 0;
  bit chk_en = 1'b0;
  bit rd_rand = 1'b0;

  // Model: a frame is a linear run of NPIX pixels; m_cnt = -1 idle, NPIX = full.
  logic [1:0] m_mem [0:1][0:NPIX-1];
  int m_cnt, m_rb, m_wb;
  bit m_shown, m_pend;
  logic [1:0] e_data;
  bit e_done, e_over, e_short, e_drop;

  task automatic check(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk_8m) begin
    if (rst) begin
      m_cnt = -1; m_shown = 1'b0; m_rb = 0; m_wb = DB ? 1 : 0; m_pend = 1'b0;
      e_data = 2'b00; e_done = 1'b0; e_over = 1'b0; e_short = 1'b0; e_drop = 1'b0;
    end else begin
      if (bus.rd_x < 160 && bus.rd_y < 144 && m_shown)
        e_data = m_mem[m_rb][int'(bus.rd_y) * 160 + int'(bus.rd_x)];
      else
        e_data = 2'b00;
      if (bus.clr_status) begin e_over = 1'b0; e_short = 1'b0; e_drop = 1'b0; end
      e_done = 1'b0;
      if (DB && bus.rd_frame_start && m_pend) begin
        m_rb = m_wb; m_pend = 1'b0; m_shown = 1'b1;
      end
      if (bus.pix_frame_start) begin
        if (m_cnt > 0 && m_cnt < NPIX) e_short = 1'b1;
        if (DB && m_pend) begin e_drop = 1'b1; m_pend = 1'b0; end
        if (DB) m_wb = 1 - m_rb;
        m_cnt = 0;
      end
      if (bus.pix_valid) begin
        if (m_cnt == NPIX) begin
          e_over = 1'b1;
        end else if (m_cnt >= 0) begin
          m_mem[m_wb][m_cnt] = bus.pix_data;
          m_cnt++;
          if (m_cnt == NPIX) begin
            e_done = 1'b1;
            if (DB) m_pend = 1'b1; else m_shown = 1'b1;
          end
        end
      end
    end
  end

  always @(negedge clk_8m) begin
    if (chk_en) begin
      check("data_out", int'(bus.data_out), int'(e_data));
      check("frame_done", int'(bus.frame_done), int'(e_done));
      check("overflow", int'(bus.overflow), int'(e_over));
      check("short_frame", int'(bus.short_frame), int'(e_short));
      check("frame_dropped", int'(bus.frame_dropped), int'(e_drop));
      if (bus.frame_done === 1'b1) done_seen++;
    end
  end

  task automatic set_rand_rd();
    int r;
    r = $urandom_range(0, 15);
    if (r == 0) begin
      bus.rd_x = 9'($urandom_range(160, 511)); bus.rd_y = 8'($urandom_range(0, 255));
    end else if (r == 1) begin
      bus.rd_x = 9'($urandom_range(0, 159));   bus.rd_y = 8'($urandom_range(144, 255));
    end else begin
      bus.rd_x = 9'($urandom_range(0, 159));   bus.rd_y = 8'($urandom_range(0, 143));
    end
  endtask

  task automatic cyc(bit pfs, bit pv, logic [1:0] pd, bit rfs);
    bus.pix_frame_start = pfs;
    bus.pix_valid       = pv;
    bus.pix_data        = pd;
    bus.rd_frame_start  = rfs;
    if (rd_rand) set_rand_rd();
    @(negedge clk_8m);
  endtask

  task automatic send_pixels(int first, int n, bit start, bit pattern, int idle_pct);
    logic [1:0] d;
    for (int p = first; p < first + n; p++) begin
      while (idle_pct > 0 && $urandom_range(0, 99) < idle_pct) cyc(1'b0, 1'b0, 2'($urandom), 1'b0);
      d = pattern ? 2'(((p % 160) ^ (p / 160)) & 3) : 2'($urandom);
      cyc(start && (p == first), 1'b1, d, 1'b0);
    end
  endtask

  task automatic read_at(string name, logic [8:0] x, logic [7:0] y, logic [1:0] exp);
    bus.rd_x = x; bus.rd_y = y;
    bus.pix_valid = 1'b0; bus.pix_frame_start = 1'b0; bus.rd_frame_start = 1'b0;
    @(negedge clk_8m);
    check(name, int'(bus.data_out), int'(exp));
  endtask

  initial begin
    #(64'd124 * 64'd100000);
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.pix_frame_start = 1'b0; bus.pix_valid = 1'b0; bus.pix_data = 2'b00;
    bus.rd_x = 9'd0; bus.rd_y = 8'd0; bus.rd_frame_start = 1'b0; bus.clr_status = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk_8m);
    chk_en = 1'b1;
    check("rst_data_out", int'(bus.data_out), 0);
    check("rst_frame_done", int'(bus.frame_done), 0);
    check("rst_overflow", int'(bus.overflow), 0);
    rst = 1'b0;

    // Pixels before any frame start are ignored.
    rd_rand = 1'b1;
    repeat (20) cyc(1'b0, 1'b1, 2'd3, 1'b0);
    rd_rand = 1'b0;
    read_at("pre_frame_0_0", 9'd0, 8'd0, 2'd0);

    // First frame, bursty, (x^y)&3 pattern.
    rd_rand = 1'b1;
    send_pixels(0, NPIX, 1'b1, 1'b1, 12);
    cyc(1'b0, 1'b0, 2'd0, 1'b0);
    check("done_count_1", done_seen, 1);

    // Extra pixels in FULL carry 3 so any write to (159,143) would be visible.
    repeat (3) cyc(1'b0, 1'b1, 2'd3, 1'b0);
    cyc(1'b0, 1'b0, 2'd0, 1'b0);
    check("overflow_set", int'(bus.overflow), 1);

    cyc(1'b0, 1'b0, 2'd0, 1'b1);
    rd_rand = 1'b0;
    read_at("read_1_2", 9'd1, 8'd2, 2'd3);
    read_at("read_159_143", 9'd159, 8'd143, 2'd0);
    read_at("read_x160", 9'd160, 8'd0, 2'd0);
    read_at("read_xneg8", 9'h1F8, 8'd0, 2'd0);
    read_at("read_y144", 9'd3, 8'd144, 2'd0);
    rd_rand = 1'b1;
    repeat (1500) cyc(1'b0, 1'b0, 2'd0, 1'b0);
    bus.clr_status = 1'b1;
    cyc(1'b0, 1'b0, 2'd0, 1'b0);
    bus.clr_status = 1'b0;
    check("overflow_clr", int'(bus.overflow), 0);

    // Short frame of 100 pixels, restart with a same-cycle pixel.
    send_pixels(0, 100, 1'b1, 1'b0, 0);
    cyc(1'b1, 1'b1, 2'd2, 1'b0);
    check("short_set", int'(bus.short_frame), 1);
`ifndef DMG_FB_DOUBLE_BUF_EN
    rd_rand = 1'b0;
    read_at("restart_0_0", 9'd0, 8'd0, 2'd2);
    rd_rand = 1'b1;
`endif
    bus.clr_status = 1'b1;
    cyc(1'b0, 1'b0, 2'd0, 1'b0);
    bus.clr_status = 1'b0;
    check("short_clr", int'(bus.short_frame), 0);

    // Complete frame 2, then frame 3 without any panel adoption.
    send_pixels(1, NPIX - 1, 1'b0, 1'b0, 0);
    cyc(1'b0, 1'b0, 2'd0, 1'b0);
    send_pixels(0, NPIX, 1'b1, 1'b0, 0);
    cyc(1'b0, 1'b0, 2'd0, 1'b0);
    check("dropped", int'(bus.frame_dropped), DB ? 1 : 0);
    check("done_count_3", done_seen, 3);
`ifdef DMG_FB_DOUBLE_BUF_EN
    rd_rand = 1'b0;
    read_at("old_bank_1_2", 9'd1, 8'd2, 2'd3);
    rd_rand = 1'b1;
`endif

    // Same-cycle panel swap and PPU frame start, then partial frame 4.
    cyc(1'b1, 1'b1, 2'($urandom), 1'b1);
    send_pixels(1, 500, 1'b0, 1'b0, 5);

    // Reset mid-frame masks the stored image.
    rst = 1'b1;
    repeat (2) cyc(1'b0, 1'b0, 2'd0, 1'b0);
    rst = 1'b0;
    rd_rand = 1'b0;
    read_at("after_rst_1_2", 9'd1, 8'd2, 2'd0);
    check("after_rst_dropped", int'(bus.frame_dropped), 0);
    rd_rand = 1'b1;
    repeat (20) cyc(1'b0, 1'b1, 2'd1, 1'b0);

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/dmg_fb_reader.md
Name: dmg_fb_reader

Overview:
- Frame buffer between the DMG PPU pixel stream and the LCD panel controller.
- Captures 160x144 2-bit pixels as the PPU emits them (PPU timing, bursty).
- Serves them back by random-access (rd_x, rd_y) lookup, driven directly from the panel controller's xpos_out/ypos_out, with data_out feeding its data_in.
- Decouples PPU frame timing from panel refresh timing.

Parameters:
- H_PIX, 160, active pixels per line.
- V_PIX, 144, active lines per frame.
- BLANK_PIX, 2'b00, value returned for out-of-range reads and before the first complete frame.

Ports:
- clk_8m  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- pix_frame_start  in  1  PPU frame-start pulse, 1 cycle.
- pix_valid  in  1  pixel strobe from PPU.
- pix_data  in  2  pixel colour index; 0 = lightest.
- rd_x  in  9  read column, 0..H_PIX-1 valid; other values (incl. wrapped negatives) are out of range.
- rd_y  in  8  read line, 0..V_PIX-1 valid.
- rd_frame_start  in  1  panel frame-boundary pulse, 1 cycle.
- data_out  out  2  registered pixel for (rd_x, rd_y).
- frame_done  out  1  1-cycle pulse, cycle after the last pixel of a frame is written.
- overflow  out  1  sticky: pix_valid received while in FULL.
- short_frame  out  1  sticky: pix_frame_start received in FILL with pixel count != 0.
- frame_dropped  out  1  sticky: completed frame overwritten before the panel adopted it (DB build only; tied 0 otherwise).
- clr_status  in  1  clears all sticky flags; same-cycle set wins.

Behaviour:
- Storage: 1 or 2 banks of H_PIX*V_PIX x 2 bits, inferred sync RAM.
- Linear address = y*160 + x, 15 bits, computed as (y<<7)+(y<<5)+x with no multiplier.
- Write counters wr_x (0..159) and wr_y (0..143).
- Write FSM states IDLE, FILL, FULL.
  - Reset: state IDLE, counters 0, all outputs 0, data_out = BLANK_PIX, frame_valid = 0.
  - IDLE: pix_valid ignored; pix_frame_start -> FILL.
  - FILL: each pix_valid writes pix_data at (wr_x, wr_y), then increments wr_x. At wr_x == 159, wr_x wraps to 0 and wr_y increments.
  - FILL: the write at (159,143) -> FULL, frame_done pulses next cycle, frame_valid set.
  - FILL: pix_frame_start with count != 0 sets short_frame, resets counters, stays FILL. Partial frame never marked complete.
  - FULL: pix_valid dropped and overflow set; pix_frame_start -> FILL with counters 0.
- pix_frame_start and pix_valid in the same cycle: counters reset first, pixel written at (0,0), wr_x becomes 1.
- Read path, latency exactly 1 cycle:
  - data_out(n+1) = mem[rd_y*160 + rd_x] sampled at cycle n.
  - If rd_x >= H_PIX, rd_y >= V_PIX, or frame_valid == 0: data_out = BLANK_PIX.
- rst mid-frame: returns to IDLE, frame_valid cleared. RAM contents are not cleared but are masked by frame_valid.
- Single-bank build: reads and writes share one bank. Tearing is permitted.

Optional Feature:
- Macro DMG_FB_DOUBLE_BUF_EN.
- Defined: two banks, read bank rb and write bank wb, pending flag.
  - On each pix_frame_start: wb := ~rb. If pending is still 1, set frame_dropped and clear pending.
  - On frame_done: pending := 1.
  - On rd_frame_start with pending == 1: rb := wb, pending := 0. The displayed bank is never written.
  - rd_frame_start and pix_frame_start in the same cycle: reader swap first, then wb := ~new rb.
  - Reset: rb = 0, wb = 1, pending = 0.
- Undefined: single bank, no pending logic, frame_dropped tied 0.

Test Plan:
- Reset, then read (0,0) -> data_out = BLANK_PIX; pixels sent before first pix_frame_start are ignored, and (0,0) still reads BLANK after a full frame is written later.
- pix_frame_start + 23040 pixels with pix_data = (x^y)&3 -> frame_done pulses once, 1 cycle after the last write; a read sweep returns the pattern with 1-cycle latency.
- Reads at rd_x = 160, rd_x = 9'h1F8 (wrapped -8) and rd_y = 144 -> BLANK_PIX.
- 100 pixels then pix_frame_start -> short_frame = 1; next pixel lands at (0,0); clr_status clears the flag.
- Full frame then 3 extra pix_valid -> overflow = 1; RAM at (159,143) unchanged.
- DB: frame A complete, no rd_frame_start, frame B started -> frame_dropped = 1 and reads still show the old bank. A second completed frame plus rd_frame_start -> reads switch on the next cycle; a same-cycle swap/start keeps wb != rb.
